// File: rtl/axis_eth_fcs_arb_if.sv
// AXI-stream bundle shared by the arbiter's request side and its engine side.
// LANES streams are packed side by side: lane i's data is at
// tdata[i*DATA_WIDTH +: DATA_WIDTH], and its keep is at tkeep[i*KEEP_WIDTH +: KEEP_WIDTH].
// The 1-bit signals tvalid/tready/tlast/tuser each have one bit per lane.
// Modports:
//   master - drives tdata/tkeep/tvalid/tlast/tuser and receives tready
//   slave  - receives tdata/tkeep/tvalid/tlast/tuser and drives tready
interface axis_eth_fcs_arb_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES*KEEP_WIDTH-1:0] tkeep;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;
    logic [LANES-1:0]            tlast;
    logic [LANES-1:0]            tuser;

    modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                    input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, input  tuser,
                    output tready);
endinterface

// File: rtl/axis_eth_fcs_arb.sv
// Frame-level round-robin arbiter that shares one FCS generator between PORTS streams.
// It grants one whole frame at a time and forwards that frame to the engine. It then tags
// the FCS that the engine returns with the source port and an error flag. A watchdog
// truncates any frame longer than MAX_BEATS and discards the rest of that frame.
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   s_axis         - PORTS requesting streams (slave side)
//   m_axis         - single stream toward the FCS engine (master side)
//   fcs_in/_valid  - FCS result from the engine, one cycle after the tlast beat
//   fcs_out*       - tagged result, with fcs_out_valid as a one-cycle strobe
module axis_eth_fcs_arb #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BEATS  = 1522,
    parameter int PORT_WIDTH = $clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_eth_fcs_arb_if.slave     s_axis,
    axis_eth_fcs_arb_if.master    m_axis,
    input  logic [31:0]           fcs_in,
    input  logic                  fcs_in_valid,
    output logic [31:0]           fcs_out,
    output logic [PORT_WIDTH-1:0] fcs_out_port,
    output logic                  fcs_out_err,
    output logic                  fcs_out_valid
);
    // beat_cnt never goes past MAX_BEATS-1: that beat either ends the frame or truncates it.
    localparam int CNT_WIDTH = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DROP} state_t;

    state_t                  state_q, state_d;
    logic [PORT_WIDTH-1:0]   grant_q, grant_d;
    logic [PORT_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic                    tag_pending_q;
    logic [PORT_WIDTH-1:0]   tag_port_q;
    logic                    tag_err_q;
    logic                    tag_set;
    logic                    tag_err_new;
    logic [31:0]             fcs_out_q;
    logic [PORT_WIDTH-1:0]   fcs_out_port_q;
    logic                    fcs_out_err_q;
    logic                    fcs_out_valid_q;

    logic [PORTS-1:0]        s_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic [KEEP_WIDTH-1:0]   m_keep;
    logic                    m_valid, m_last, m_user;
    logic                    found;
    logic [PORT_WIDTH-1:0]   cand;
    logic                    hs;

    // Per-port views of the packed request bus.
    logic [DATA_WIDTH-1:0]   s_data_a [PORTS];
    logic [KEEP_WIDTH-1:0]   s_keep_a [PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_unpack
            assign s_data_a[gi] = s_axis.tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_keep_a[gi] = s_axis.tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        tag_set      = 1'b0;
        tag_err_new  = 1'b0;
        s_ready      = '0;
        m_data       = '0;
        m_keep       = '0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        m_user       = 1'b0;
        found        = 1'b0;
        cand         = '0;
        hs           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Scan from the port after the last winner, so that a port which re-requests
                // is served only after every other pending port.
                for (int i = 1; i <= PORTS; i++) begin
                    cand = PORT_WIDTH'((int'(last_grant_q) + i) % PORTS);
                    if (!found && s_axis.tvalid[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    last_grant_d = grant_d;
                    beat_cnt_d   = '0;
                    state_d      = ST_XFER;
                end
            end

            ST_XFER: begin
                m_data            = s_data_a[grant_q];
                m_keep            = s_keep_a[grant_q];
                m_valid           = s_axis.tvalid[grant_q];
                m_last            = s_axis.tlast[grant_q];
                m_user            = s_axis.tuser[grant_q];
                s_ready[grant_q]  = m_axis.tready;
                hs                = m_valid && m_axis.tready;
                if (s_axis.tlast[grant_q]) begin
                    if (hs) begin
                        tag_set     = 1'b1;
                        tag_err_new = s_axis.tuser[grant_q];
                        state_d     = ST_IDLE;
                    end
                end else if (beat_cnt_q == CNT_WIDTH'(MAX_BEATS - 1)) begin
                    // Watchdog: close the frame on the engine side and flag it bad.
                    m_last = 1'b1;
                    m_user = 1'b1;
                    if (hs) begin
                        tag_set     = 1'b1;
                        tag_err_new = 1'b1;
                        state_d     = ST_DROP;
                    end
                end else if (hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end

            ST_DROP: begin
                s_ready[grant_q] = 1'b1;
                if (s_axis.tvalid[grant_q] && s_axis.tlast[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_WIDTH'(PORTS - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // A new tag takes priority over consuming the old one. The dead IDLE cycle means the two
    // never happen for consecutive frames in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pending_q   <= 1'b0;
            tag_port_q      <= '0;
            tag_err_q       <= 1'b0;
            fcs_out_q       <= '0;
            fcs_out_port_q  <= '0;
            fcs_out_err_q   <= 1'b0;
            fcs_out_valid_q <= 1'b0;
        end else begin
            fcs_out_valid_q <= fcs_in_valid && tag_pending_q;
            if (fcs_in_valid && tag_pending_q) begin
                fcs_out_q      <= fcs_in;
                fcs_out_port_q <= tag_port_q;
                fcs_out_err_q  <= tag_err_q;
            end
            if (tag_set) begin
                tag_pending_q <= 1'b1;
                tag_port_q    <= grant_q;
                tag_err_q     <= tag_err_new;
            end else if (fcs_in_valid && tag_pending_q) begin
                tag_pending_q <= 1'b0;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data;
    assign m_axis.tkeep  = m_keep;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = m_last;
    assign m_axis.tuser  = m_user;
    assign fcs_out       = fcs_out_q;
    assign fcs_out_port  = fcs_out_port_q;
    assign fcs_out_err   = fcs_out_err_q;
    assign fcs_out_valid = fcs_out_valid_q;
endmodule

// File: tb/tb_axis_eth_fcs_arb.sv
// Directed bench for axis_eth_fcs_arb (PORTS=4, DATA_WIDTH=8, MAX_BEATS=8).
// The source beat data is {port[3:0], beat_index[3:0]}, with beat_index starting at 1.
// The engine model returns 32'hC0DE0000+n for the n-th frame of a scenario.
module tb_axis_eth_fcs_arb;
    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int KW    = 1;
    localparam int MAXB  = 8;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       user;
    } beat_t;
    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       user;
        logic [0:0] keep;
        int         cyc;
    } mon_t;
    typedef struct {
        logic [31:0] v;
        logic [1:0]  port;
        logic        err;
        int          cyc;
    } fcs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fcs_in;
    logic        fcs_in_valid;
    logic [31:0] fcs_out;
    logic [1:0]  fcs_out_port;
    logic        fcs_out_err;
    logic        fcs_out_valid;

    axis_eth_fcs_arb_if #(.LANES(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
    axis_eth_fcs_arb_if #(.LANES(1),     .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

    axis_eth_fcs_arb #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MAXB), .PORT_WIDTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .fcs_in        (fcs_in),
        .fcs_in_valid  (fcs_in_valid),
        .fcs_out       (fcs_out),
        .fcs_out_port  (fcs_out_port),
        .fcs_out_err   (fcs_out_err),
        .fcs_out_valid (fcs_out_valid)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t src_q [PORTS][$];
    mon_t  mon_q [$];
    fcs_t  fcs_q [$];
    int    vectors = 0;
    int    miscompares = 0;
    int    eng_cnt = 0;
    bit    eng_fixed_en = 0;
    logic [31:0] eng_fixed = 32'h0;
    bit    toggle_ready = 0;
    bit    spur_req = 0;
    int    mirror_err = 0;

    // Source / engine / monitor loop: it samples at the negedge and drives 1 ns after the posedge.
    initial begin : bfm
        bit   hs [PORTS];
        bit   eng_fire;
        int   gp;
        s_if.tdata   = '0;
        s_if.tkeep   = '0;
        s_if.tvalid  = '0;
        s_if.tlast   = '0;
        s_if.tuser   = '0;
        m_if.tready  = 1'b1;
        fcs_in       = '0;
        fcs_in_valid = 1'b0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < PORTS; p++) hs[p] = s_if.tvalid[p] && s_if.tready[p];
            eng_fire = 1'b0;
            if (m_if.tvalid[0]) begin
                gp = int'(m_if.tdata[7:4]);
                if (gp < PORTS) begin
                    if (s_if.tready[gp] !== m_if.tready[0]) mirror_err++;
                    if ((s_if.tready & ~(4'b0001 << gp)) !== 4'b0000) mirror_err++;
                end
                if (m_if.tready[0]) begin
                    mon_q.push_back('{m_if.tdata, m_if.tlast[0], m_if.tuser[0], m_if.tkeep, cyc});
                    eng_fire = m_if.tlast[0];
                end
            end
            if (fcs_out_valid) fcs_q.push_back('{fcs_out, fcs_out_port, fcs_out_err, cyc});
            @(posedge clk);
            #1;
            for (int p = 0; p < PORTS; p++) begin
                if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    s_if.tvalid[p]          = 1'b1;
                    s_if.tdata[p*DW +: DW]  = src_q[p][0].d;
                    s_if.tkeep[p]           = 1'b1;
                    s_if.tlast[p]           = src_q[p][0].last;
                    s_if.tuser[p]           = src_q[p][0].user;
                end else begin
                    s_if.tvalid[p]          = 1'b0;
                    s_if.tdata[p*DW +: DW]  = 8'h00;
                    s_if.tkeep[p]           = 1'b0;
                    s_if.tlast[p]           = 1'b0;
                    s_if.tuser[p]           = 1'b0;
                end
            end
            fcs_in_valid = eng_fire || spur_req;
            if (eng_fire) begin
                fcs_in = eng_fixed_en ? eng_fixed : 32'hC0DE0000 + 32'(eng_cnt);
                eng_cnt++;
            end else begin
                fcs_in = 32'h5555AAAA;
            end
            spur_req = 1'b0;
            if (toggle_ready) m_if.tready[0] = ~m_if.tready[0];
        end
    end

    task automatic push_frame(input int p, input int n, input logic user);
        beat_t b;
        for (int i = 1; i <= n; i++) begin
            b.d    = 8'((p << 4) | i);
            b.last = (i == n);
            b.user = user && (i == n);
            src_q[p].push_back(b);
        end
    endtask

    task automatic start_scenario();
        @(posedge clk);
        #3;
        mon_q.delete();
        fcs_q.delete();
        eng_cnt = 0;
    endtask

    task automatic wait_done(input int n_fcs, output bit ok);
        int pend;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!ok) begin
                @(posedge clk);
                #3;
                pend = 0;
                for (int p = 0; p < PORTS; p++) pend += src_q[p].size();
                if (pend == 0 && fcs_q.size() >= n_fcs) ok = 1'b1;
            end
        end
        repeat (4) @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        mon_q.delete();
        fcs_q.delete();
        for (int p = 0; p < PORTS; p++) push_frame(p, 1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (s_if.tready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_tready got=%b want=0000", s_if.tready);
        end
        vectors++;
        if (m_if.tvalid[0] !== 1'b0 || m_if.tlast[0] !== 1'b0 || m_if.tuser[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_m_axis got v/l/u=%b%b%b want=000", m_if.tvalid[0], m_if.tlast[0], m_if.tuser[0]);
        end
        vectors++;
        if (fcs_out_valid !== 1'b0 || fcs_out !== 32'h0 || fcs_out_port !== 2'd0 || fcs_out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fcs_out got v=%b fcs=%h port=%0d err=%b want all zero",
                     fcs_out_valid, fcs_out, fcs_out_port, fcs_out_err);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_done(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reset_timeout got fcs_count=%0d want=4", fcs_q.size());
        end
        vectors++;
        if (mon_q.size() < 1 || mon_q[0].d !== 8'h01) begin
            miscompares++;
            $display("FAIL reset_first_grant got data=%h want=01", mon_q.size() > 0 ? mon_q[0].d : 8'hxx);
        end
        $display("reset: first beat=%h, frames=%0d", mon_q.size() > 0 ? mon_q[0].d : 8'hxx, fcs_q.size());
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [7:0] exp_d;
        start_scenario();
        for (int p = 0; p < PORTS; p++) push_frame(p, 4, 1'b0);
        wait_done(4, ok);
        vectors++;
        if (!ok || mon_q.size() != 16 || fcs_q.size() != 4) begin
            miscompares++;
            $display("FAIL rr_count got beats=%0d fcs=%0d want 16/4", mon_q.size(), fcs_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp_d = 8'(((i / 4) << 4) | (i % 4 + 1));
                vectors++;
                if (mon_q[i].d !== exp_d || mon_q[i].last !== (i % 4 == 3) || mon_q[i].user !== 1'b0
                    || mon_q[i].keep !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rr_beat%0d got d=%h l=%b u=%b k=%b want d=%h l=%b u=0 k=1", i,
                             mon_q[i].d, mon_q[i].last, mon_q[i].user, mon_q[i].keep, exp_d, (i % 4 == 3));
                end
            end
            for (int f = 1; f < 4; f++) begin
                vectors++;
                if (mon_q[f*4].cyc - mon_q[f*4-1].cyc != 2) begin
                    miscompares++;
                    $display("FAIL rr_gap%0d got=%0d want=2", f, mon_q[f*4].cyc - mon_q[f*4-1].cyc);
                end
            end
            for (int f = 0; f < 4; f++) begin
                vectors++;
                if (fcs_q[f].port !== 2'(f) || fcs_q[f].err !== 1'b0 || fcs_q[f].v !== 32'hC0DE0000 + 32'(f)
                    || fcs_q[f].cyc - mon_q[f*4+3].cyc != 2) begin
                    miscompares++;
                    $display("FAIL rr_tag%0d got port=%0d err=%b fcs=%h lat=%0d want port=%0d err=0 fcs=%h lat=2",
                             f, fcs_q[f].port, fcs_q[f].err, fcs_q[f].v, fcs_q[f].cyc - mon_q[f*4+3].cyc,
                             f, 32'hC0DE0000 + 32'(f));
                end
            end
        end
        $display("round_robin: beats=%0d frames=%0d", mon_q.size(), fcs_q.size());
    endtask

    task automatic test_fairness();
        bit ok;
        logic [1:0] exp_p;
        start_scenario();
        for (int k = 0; k < 3; k++) begin
            push_frame(1, 2, 1'b0);
            push_frame(3, 2, 1'b0);
        end
        wait_done(6, ok);
        vectors++;
        if (!ok || fcs_q.size() != 6) begin
            miscompares++;
            $display("FAIL fair_count got fcs=%0d want=6", fcs_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                exp_p = (k % 2 == 0) ? 2'd1 : 2'd3;
                vectors++;
                if (fcs_q[k].port !== exp_p) begin
                    miscompares++;
                    $display("FAIL fair_grant%0d got=%0d want=%0d", k, fcs_q[k].port, exp_p);
                end
            end
        end
        $display("fairness: frames=%0d", fcs_q.size());
    endtask

    task automatic test_backpressure();
        bit ok;
        start_scenario();
        mirror_err = 0;
        toggle_ready = 1'b1;
        push_frame(0, 6, 1'b0);
        wait_done(1, ok);
        toggle_ready = 1'b0;
        m_if.tready[0] = 1'b1;
        vectors++;
        if (!ok || mon_q.size() != 6) begin
            miscompares++;
            $display("FAIL bp_count got beats=%0d want=6", mon_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (mon_q[i].d !== 8'(i + 1) || mon_q[i].last !== (i == 5)) begin
                    miscompares++;
                    $display("FAIL bp_beat%0d got d=%h l=%b want d=%h l=%b", i, mon_q[i].d, mon_q[i].last,
                             8'(i + 1), (i == 5));
                end
            end
        end
        vectors++;
        if (mirror_err != 0) begin
            miscompares++;
            $display("FAIL bp_tready_mirror got errors=%0d want=0", mirror_err);
        end
        $display("backpressure: beats=%0d mirror_errors=%0d", mon_q.size(), mirror_err);
    endtask

    task automatic test_watchdog();
        bit ok;
        start_scenario();
        push_frame(2, 12, 1'b0);
        wait_done(1, ok);
        repeat (4) @(posedge clk);
        #3;
        vectors++;
        if (!ok || mon_q.size() != 8 || fcs_q.size() != 1) begin
            miscompares++;
            $display("FAIL wd_count got beats=%0d fcs=%0d want 8/1", mon_q.size(), fcs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (mon_q[i].d !== 8'(8'h20 + i + 1) || mon_q[i].last !== (i == 7) || mon_q[i].user !== (i == 7)) begin
                    miscompares++;
                    $display("FAIL wd_beat%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", i, mon_q[i].d,
                             mon_q[i].last, mon_q[i].user, 8'(8'h20 + i + 1), (i == 7), (i == 7));
                end
            end
            vectors++;
            if (fcs_q[0].port !== 2'd2 || fcs_q[0].err !== 1'b1) begin
                miscompares++;
                $display("FAIL wd_tag got port=%0d err=%b want port=2 err=1", fcs_q[0].port, fcs_q[0].err);
            end
        end
        vectors++;
        if (src_q[2].size() != 0) begin
            miscompares++;
            $display("FAIL wd_drain got left=%0d want=0", src_q[2].size());
        end
        $display("watchdog: beats=%0d frames=%0d", mon_q.size(), fcs_q.size());
    endtask

    task automatic test_error_tag();
        bit ok;
        start_scenario();
        eng_fixed_en = 1'b1;
        eng_fixed    = 32'hDEADBEEF;
        push_frame(0, 1, 1'b1);
        wait_done(1, ok);
        repeat (3) @(posedge clk);
        #3;
        eng_fixed_en = 1'b0;
        vectors++;
        if (!ok || mon_q.size() != 1 || fcs_q.size() != 1) begin
            miscompares++;
            $display("FAIL err_count got beats=%0d strobes=%0d want 1/1", mon_q.size(), fcs_q.size());
        end else begin
            vectors++;
            if (mon_q[0].last !== 1'b1 || mon_q[0].user !== 1'b1 || mon_q[0].d !== 8'h01) begin
                miscompares++;
                $display("FAIL err_beat got d=%h l=%b u=%b want d=01 l=1 u=1", mon_q[0].d, mon_q[0].last, mon_q[0].user);
            end
            vectors++;
            if (fcs_q[0].v !== 32'hDEADBEEF || fcs_q[0].err !== 1'b1 || fcs_q[0].port !== 2'd0
                || fcs_q[0].cyc - mon_q[0].cyc != 2) begin
                miscompares++;
                $display("FAIL err_tag got fcs=%h err=%b port=%0d lat=%0d want DEADBEEF 1 0 2",
                         fcs_q[0].v, fcs_q[0].err, fcs_q[0].port, fcs_q[0].cyc - mon_q[0].cyc);
            end
        end
        $display("error_tag: fcs=%h err=%b", fcs_q.size() > 0 ? fcs_q[0].v : 32'hx, fcs_q.size() > 0 ? fcs_q[0].err : 1'bx);
    endtask

    task automatic test_spurious_fcs();
        start_scenario();
        spur_req = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        vectors++;
        if (fcs_q.size() != 0) begin
            miscompares++;
            $display("FAIL spurious_fcs got strobes=%0d want=0", fcs_q.size());
        end
        $display("spurious_fcs: strobes=%0d", fcs_q.size());
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_error_tag();
        test_spurious_fcs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
